// File: rtl/kmeans_pkg.sv
// ============================================================================
// Module      : kmeans_pkg
// Description : Shared types, constants and helpers for the K-means core array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kmeans_pkg;

  localparam logic MODE_PACKED = 1'b0;
  localparam logic MODE_SPREAD = 1'b1;

  // Widest mask popcount() accepts; narrower masks are zero-extended by the caller.
  localparam int MAX_CORES = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    DRAIN = 2'd2
  } alloc_state_t;

  function automatic int unsigned popcount(input logic [MAX_CORES-1:0] v);
    int unsigned c;
    c = 0;
    for (int j = 0; j < MAX_CORES; j++) begin
      c = c + 32'(v[j]);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kmask_gen.sv
// ============================================================================
// Module      : kmask_gen
// Description : Serial core-enable mask builder, one mask bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kmask_gen
  import kmeans_pkg::*;
#(
  parameter int N_CORES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(N_CORES+1)-1:0] k_in,
  input  logic                         mode_in,
  output logic [N_CORES-1:0]           new_mask,
  output logic                         last
);

  localparam int KW = $clog2(N_CORES + 1);
  localparam int IW = $clog2(N_CORES);
  localparam logic [IW-1:0] LAST_I  = IW'(N_CORES - 1);
  localparam logic [KW:0]   N_WIDE  = (KW+1)'(N_CORES);

  logic               running_q, running_d;
  logic [IW-1:0]      i_q, i_d;
  logic [KW:0]        acc_q, acc_d;
  logic [KW-1:0]      k_q, k_d;
  logic               mode_q, mode_d;
  logic [N_CORES-1:0] new_mask_q, new_mask_d;

  logic [KW:0]        acc_sum;
  logic               bit_val;

  always_comb begin
    running_d  = running_q;
    i_d        = i_q;
    acc_d      = acc_q;
    k_d        = k_q;
    mode_d     = mode_q;
    new_mask_d = new_mask_q;

    // Bresenham-style accumulator: k_eff <= N_CORES keeps one subtract enough.
    acc_sum = acc_q + {1'b0, k_q};
    if (acc_sum >= N_WIDE) begin
      acc_sum = acc_sum - N_WIDE;
    end

    if (mode_q == MODE_SPREAD) begin
      bit_val = (acc_q < {1'b0, k_q});
    end else begin
      bit_val = (KW'(i_q) < k_q);
    end

    if (start) begin
      running_d  = 1'b1;
      i_d        = '0;
      acc_d      = '0;
      k_d        = k_in;
      mode_d     = mode_in;
      new_mask_d = '0;
    end else if (running_q) begin
      new_mask_d[i_q] = bit_val;
      acc_d           = acc_sum;
      i_d             = i_q + 1'b1;
      if (i_q == LAST_I) begin
        running_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q  <= 1'b0;
      i_q        <= '0;
      acc_q      <= '0;
      k_q        <= '0;
      mode_q     <= MODE_PACKED;
      new_mask_q <= '0;
    end else begin
      running_q  <= running_d;
      i_q        <= i_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      mode_q     <= mode_d;
      new_mask_q <= new_mask_d;
    end
  end

  assign new_mask = new_mask_q;
  assign last     = running_q && (i_q == LAST_I);

endmodule

`default_nettype wire

// File: rtl/core_alloc_ctrl.sv
// ============================================================================
// Module      : core_alloc_ctrl
// Description : Core-enable allocator: accept k/mode, build mask, drain, commit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_alloc_ctrl
  import kmeans_pkg::*;
#(
  parameter int N_CORES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [$clog2(N_CORES+1)-1:0] cfg_k,
  input  logic                         cfg_mode,
  output logic                         cfg_done,
  output logic                         cfg_err,
  input  logic [N_CORES-1:0]           core_busy,
  output logic [N_CORES-1:0]           core_halt,
  output logic [N_CORES-1:0]           en,
  output logic [$clog2(N_CORES+1)-1:0] active_count
);

  localparam int KW = $clog2(N_CORES + 1);
  localparam logic [KW-1:0] N_K = KW'(N_CORES);

  alloc_state_t       state_q, state_d;
  logic [N_CORES-1:0] en_q, en_d;
  logic [KW-1:0]      active_count_q, active_count_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               err_flag_q, err_flag_d;

  logic                 accept;
  logic [KW-1:0]        k_eff;
  logic [N_CORES-1:0]   new_mask;
  logic                 last;
  logic [MAX_CORES-1:0] mask_wide;
  logic [N_CORES-1:0]   dropping;
  logic                 conflict;

  assign accept = cfg_valid && (state_q == IDLE);
  assign k_eff  = (cfg_k > N_K) ? N_K : cfg_k;

  kmask_gen #(
    .N_CORES (N_CORES)
  ) u_kmask_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept),
    .k_in     (k_eff),
    .mode_in  (cfg_mode),
    .new_mask (new_mask),
    .last     (last)
  );

  // Cores going from enabled to disabled; only these are gated by busy.
  assign dropping = en_q & ~new_mask;
  assign conflict = |(core_busy & dropping);

  always_comb begin
    mask_wide                = '0;
    mask_wide[N_CORES-1:0]   = new_mask;
  end

  always_comb begin
    state_d        = state_q;
    en_d           = en_q;
    active_count_d = active_count_q;
    done_d         = 1'b0;
    err_d          = 1'b0;
    err_flag_d     = err_flag_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          err_flag_d = (cfg_k > N_K);
          state_d    = BUILD;
        end
      end
      BUILD: begin
        if (last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!conflict) begin
          en_d           = new_mask;
          active_count_d = KW'(popcount(mask_wide));
          done_d         = 1'b1;
          err_d          = err_flag_q;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      en_q           <= N_CORES'(1);
      active_count_q <= KW'(1);
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      err_flag_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      en_q           <= en_d;
      active_count_q <= active_count_d;
      done_q         <= done_d;
      err_q          <= err_d;
      err_flag_q     <= err_flag_d;
    end
  end

  assign cfg_ready    = (state_q == IDLE);
  assign cfg_done     = done_q;
  assign cfg_err      = err_q;
  assign core_halt    = (state_q == DRAIN) ? dropping : '0;
  assign en           = en_q;
  assign active_count = active_count_q;

endmodule

`default_nettype wire

// File: tb/tb_core_alloc_ctrl.sv
// ============================================================================
// Module      : tb_core_alloc_ctrl
// Description : Directed vector bench for core_alloc_ctrl with N_CORES = 16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_alloc_ctrl;

  localparam int N  = 16;
  localparam int KW = 5;

  logic          clk;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [KW-1:0] cfg_k;
  logic          cfg_mode;
  logic          cfg_done;
  logic          cfg_err;
  logic [N-1:0]  core_busy;
  logic [N-1:0]  core_halt;
  logic [N-1:0]  en;
  logic [KW-1:0] active_count;

  int checks;
  int errors;

  core_alloc_ctrl #(
    .N_CORES (N)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_k        (cfg_k),
    .cfg_mode     (cfg_mode),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .core_busy    (core_busy),
    .core_halt    (core_halt),
    .en           (en),
    .active_count (active_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          mode;
    logic [KW-1:0] k;
    logic [N-1:0]  exp_en;
    logic [KW-1:0] exp_cnt;
    logic          exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one configuration; returns edges from accept to cfg_done (bounded).
  task automatic do_cfg(input logic mode, input logic [KW-1:0] k,
                        output int lat, output logic rdy_mid);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_k     = k;
    cfg_mode  = mode;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    lat       = 0;
    rdy_mid   = 1'b1;
    while (!cfg_done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) rdy_mid = cfg_ready;
    end
  endtask

  initial begin
    int   lat;
    logic rdy_mid;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_k     = '0;
    cfg_mode  = 1'b0;
    core_busy = '0;

    vecs[0] = '{1'b1, 5'd4,  16'h1111, 5'd4,  1'b0};
    vecs[1] = '{1'b1, 5'd5,  16'h2491, 5'd5,  1'b0};
    vecs[2] = '{1'b1, 5'd16, 16'hFFFF, 5'd16, 1'b0};
    vecs[3] = '{1'b0, 5'd0,  16'h0000, 5'd0,  1'b0};
    vecs[4] = '{1'b0, 5'd3,  16'h0007, 5'd3,  1'b0};
    vecs[5] = '{1'b1, 5'd8,  16'h5555, 5'd8,  1'b0};
    vecs[6] = '{1'b0, 5'd9,  16'h01FF, 5'd9,  1'b0};
    vecs[7] = '{1'b0, 5'd20, 16'hFFFF, 5'd16, 1'b1};
    vecs[8] = '{1'b0, 5'd16, 16'hFFFF, 5'd16, 1'b0};
    vecs[9] = '{1'b1, 5'd31, 16'hFFFF, 5'd16, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_en",    32'(en), 32'h0001);
    chk("reset_count", 32'(active_count), 32'd1);
    chk("reset_ready", 32'(cfg_ready), 32'd1);
    chk("reset_halt",  32'(core_halt), 32'd0);
    chk("reset_done",  32'(cfg_done), 32'd0);

    for (int v = 0; v < 10; v++) begin
      do_cfg(vecs[v].mode, vecs[v].k, lat, rdy_mid);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'd17);
      chk($sformatf("v%0d_ready_mid", v), 32'(rdy_mid), 32'd0);
      chk($sformatf("v%0d_en", v), 32'(en), 32'(vecs[v].exp_en));
      chk($sformatf("v%0d_count", v), 32'(active_count), 32'(vecs[v].exp_cnt));
      chk($sformatf("v%0d_err", v), 32'(cfg_err), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_ready", v), 32'(cfg_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", v), 32'(cfg_done), 32'd0);
      chk($sformatf("v%0d_err_pulse", v), 32'(cfg_err), 32'd0);
    end

    // Drain: en = FFFF, shrink to core 0 while core 5 (dropping) and core 0 (kept) are busy.
    @(negedge clk);
    core_busy = 16'h0021;
    cfg_valid = 1'b1;
    cfg_k     = 5'd1;
    cfg_mode  = 1'b0;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    for (int e = 0; e < 16; e++) begin
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("drain%0d_halt", c), 32'(core_halt), 32'h0000FFFE);
      chk($sformatf("drain%0d_en", c), 32'(en), 32'h0000FFFF);
      chk($sformatf("drain%0d_done", c), 32'(cfg_done), 32'd0);
      if (c < 9) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    core_busy = 16'h0001;
    @(posedge clk);
    #1;
    chk("drain_commit_en",    32'(en), 32'h0001);
    chk("drain_commit_done",  32'(cfg_done), 32'd1);
    chk("drain_commit_count", 32'(active_count), 32'd1);
    chk("drain_commit_halt",  32'(core_halt), 32'd0);
    core_busy = '0;

    // Reset in the middle of BUILD.
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_k     = 5'd16;
    cfg_mode  = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midbuild_ready", 32'(cfg_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_en",    32'(en), 32'h0001);
    chk("rst_mid_count", 32'(active_count), 32'd1);
    chk("rst_mid_ready", 32'(cfg_ready), 32'd1);
    chk("rst_mid_done",  32'(cfg_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 30; c++) begin
        @(posedge clk);
        #1;
        if (cfg_done) seen++;
      end
      chk("rst_no_done", 32'(seen), 32'd0);
      chk("rst_en_hold", 32'(en), 32'h0001);
    end

    do_cfg(1'b0, 5'd2, lat, rdy_mid);
    chk("post_rst_latency", 32'(lat), 32'd17);
    chk("post_rst_en",      32'(en), 32'h0003);
    chk("post_rst_count",   32'(active_count), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
